// File: rtl/nand_arb_pkg.sv
// Shared types and helpers for the NAND-bank arbiter: FSM encoding, stats width, one-hot decode.
package nand_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam int STAT_CNT_W = 16;
   localparam int MAX_REQ    = 32;

   // Callers truncate the result to their own requester count.
   function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
      return MAX_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/my_nand.sv
// Single-bit NAND cell; the arbiter owns a WIDTH-wide bank of these.
module my_nand (
   input  logic A,
   input  logic B,
   output logic Y
);

   assign Y = ~(A & B);

endmodule

// File: rtl/nand_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N_REQ.
module nand_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   last,
   output logic [IDW-1:0]   winner,
   output logic             any
);

   logic [IDW-1:0] cand;

   always_comb begin
      winner = '0;
      any    = 1'b0;
      cand   = last;
      // The previous winner is examined last, so it cannot starve the others.
      for (int k = 0; k < N_REQ; k++) begin
         if (cand == IDW'(N_REQ - 1)) cand = '0;
         else                         cand = cand + 1'b1;
         if (!any && req[cand]) begin
            any    = 1'b1;
            winner = cand;
         end
      end
   end

endmodule

// File: rtl/nand_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit my_nand bank among N_REQ requesters.
// Optional per-requester grant counters are enabled with `define NAND_ARB_STATS_EN.
module nand_share_arbiter
   import nand_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   a_in,
   input  logic [N_REQ*WIDTH-1:0]   b_in,
   output logic [N_REQ-1:0]         gnt,
   output logic                     rsp_valid,
   output logic [$clog2(N_REQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]         rsp_y,
`ifdef NAND_ARB_STATS_EN
   output logic [N_REQ*STAT_CNT_W-1:0] grant_cnt,
`endif
   input  logic                     rsp_ready
);

   localparam int IDW = $clog2(N_REQ);
   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_ISSUE = ISSUE;
   localparam logic [1:0] ST_HOLD  = HOLD;
   localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

   logic [1:0]       state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [WIDTH-1:0] a_op_q, a_op_d;
   logic [WIDTH-1:0] b_op_q, b_op_d;

   logic [IDW-1:0]   winner_w;
   logic             any_w;
   logic [WIDTH-1:0] nand_y_w;

   nand_rr_pick #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_pick (
      .req    (req),
      .last   (last_q),
      .winner (winner_w),
      .any    (any_w)
   );

   for (genvar g = 0; g < WIDTH; g++) begin : g_nand
      my_nand u_nand (
         .A (a_op_q[g]),
         .B (b_op_q[g]),
         .Y (nand_y_w[g])
      );
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = '0;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_y_d     = rsp_y_q;
      last_d      = last_q;
      a_op_d      = a_op_q;
      b_op_d      = b_op_q;
      case (state_q)
         ST_IDLE: begin
            if (any_w) begin
               for (int i = 0; i < N_REQ; i++) begin
                  if (winner_w == IDW'(i)) begin
                     a_op_d = a_in[i*WIDTH +: WIDTH];
                     b_op_d = b_in[i*WIDTH +: WIDTH];
                  end
               end
               gnt_d   = N_REQ'(onehot(32'(winner_w)));
               last_d  = winner_w;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // last_q already holds the requester captured at grant.
            rsp_y_d     = nand_y_w;
            rsp_id_d    = last_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_y_q     <= '0;
         last_q      <= LAST_RST;
         a_op_q      <= '0;
         b_op_q      <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_y_q     <= rsp_y_d;
         last_q      <= last_d;
         a_op_q      <= a_op_d;
         b_op_q      <= b_op_d;
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_y     = rsp_y_q;

`ifdef NAND_ARB_STATS_EN
   for (genvar s = 0; s < N_REQ; s++) begin : g_stat
      logic [STAT_CNT_W-1:0] cnt_q, cnt_d;

      // Counts the grant pulse itself and sticks at all-ones.
      always_comb begin
         cnt_d = cnt_q;
         if (gnt_q[s] && (cnt_q != {STAT_CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk) begin
         if (rst) cnt_q <= '0;
         else     cnt_q <= cnt_d;
      end

      assign grant_cnt[s*STAT_CNT_W +: STAT_CNT_W] = cnt_q;
   end
`endif

endmodule

// File: tb/tb_nand_share_arbiter.sv
// Directed bench for nand_share_arbiter: vector table plus multi-cycle corner sequences.
module tb_nand_share_arbiter;

   localparam int N_REQ = 4;
   localparam int WIDTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] a_in, b_in;
   logic [3:0]  gnt;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_y;
   logic        rsp_ready;
`ifdef NAND_ARB_STATS_EN
   logic [63:0] grant_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nand_share_arbiter #(
      .N_REQ (N_REQ),
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
`ifdef NAND_ARB_STATS_EN
      .grant_cnt (grant_cnt),
`endif
      .rsp_ready (rsp_ready)
   );

   typedef struct {
      logic [3:0] req;
      int         slot;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] gnt;
      logic [1:0] id;
      logic [7:0] y;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Non-selected slices carry filler so a wrong slice choice shows up in rsp_y.
   task automatic set_ops(input int slot, input logic [7:0] a, input logic [7:0] b);
      a_in = {4{8'h5A}};
      b_in = {4{8'hC3}};
      a_in[slot*8 +: 8] = a;
      b_in[slot*8 +: 8] = b;
   endtask

   task automatic drain();
      req       = '0;
      rsp_ready = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{4'b0100, 2, 8'hF0, 8'hCC, 4'b0100, 2'd2, 8'h3F};
      tbl[1] = '{4'b1001, 3, 8'hAA, 8'h55, 4'b1000, 2'd3, 8'hFF};
      tbl[2] = '{4'b1001, 0, 8'h12, 8'h34, 4'b0001, 2'd0, 8'hEF};
      tbl[3] = '{4'b0110, 1, 8'hFF, 8'h0F, 4'b0010, 2'd1, 8'hF0};
      tbl[4] = '{4'b0001, 0, 8'h00, 8'h00, 4'b0001, 2'd0, 8'hFF};
      tbl[5] = '{4'b1000, 3, 8'hFF, 8'hFF, 4'b1000, 2'd3, 8'h00};

      // Reset held with all requests asserted
      rst       = 1'b1;
      req       = 4'hF;
      rsp_ready = 1'b1;
      set_ops(0, 8'h00, 8'h00);
      repeat (2) begin
         @(negedge clk);
         chk("rst_gnt", 32'(gnt), 32'h0);
         chk("rst_valid", 32'(rsp_valid), 32'h0);
         chk("rst_y", 32'(rsp_y), 32'h0);
      end
      chk("rst_id", 32'(rsp_id), 32'h0);
`ifdef NAND_ARB_STATS_EN
      chk("rst_cnt", grant_cnt[31:0], 32'h0);
`endif
      rst = 1'b0;

      // Vector table, each operation started from IDLE
      for (int v = 0; v < 6; v++) begin
         req = tbl[v].req;
         set_ops(tbl[v].slot, tbl[v].a, tbl[v].b);
         @(negedge clk);
         chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(tbl[v].gnt));
         req = '0;
         @(negedge clk);
         chk($sformatf("v%0d_valid", v), 32'(rsp_valid), 32'h1);
         chk($sformatf("v%0d_id", v), 32'(rsp_id), 32'(tbl[v].id));
         chk($sformatf("v%0d_y", v), 32'(rsp_y), 32'(tbl[v].y));
         chk($sformatf("v%0d_gnt_off", v), 32'(gnt), 32'h0);
         @(negedge clk);
         chk($sformatf("v%0d_valid_off", v), 32'(rsp_valid), 32'h0);
      end

      // Round robin from reset: grants 0,1,2,3,0 three cycles apart
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      req       = 4'hF;
      rsp_ready = 1'b1;
      set_ops(0, 8'h0F, 8'h0F);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if ((k - 1) % 3 == 0)
            chk($sformatf("rr_gnt_c%0d", k), 32'(gnt), 32'(4'b0001 << (((k - 1) / 3) % 4)));
         else
            chk($sformatf("rr_gnt_c%0d", k), 32'(gnt), 32'h0);
         if ((k - 1) % 3 == 1)
            chk($sformatf("rr_id_c%0d", k), 32'(rsp_id), 32'(((k - 1) / 3) % 4));
      end
      drain();
`ifdef NAND_ARB_STATS_EN
      chk("rr_cnt0", 32'(grant_cnt[15:0]), 32'd2);
      chk("rr_cnt3", 32'(grant_cnt[63:48]), 32'd1);
`endif

      // Backpressure: result held while ready is low, requests ignored
      req       = 4'b0010;
      rsp_ready = 1'b0;
      set_ops(1, 8'h0F, 8'hFF);
      @(negedge clk);
      chk("bp_gnt", 32'(gnt), 32'h2);
      req = 4'hF;
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_y", 32'(rsp_y), 32'hF0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp_hold_valid%0d", k), 32'(rsp_valid), 32'h1);
         chk($sformatf("bp_hold_y%0d", k), 32'(rsp_y), 32'hF0);
         chk($sformatf("bp_hold_gnt%0d", k), 32'(gnt), 32'h0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 32'(rsp_valid), 32'h0);
      chk("bp_release_gnt", 32'(gnt), 32'h0);
      @(negedge clk);
      chk("bp_next_gnt", 32'(gnt), 32'h4);
      drain();

      // Operand change in the grant cycle must not affect the result
      req = 4'b0001;
      set_ops(0, 8'hFF, 8'hFF);
      @(negedge clk);
      chk("stab_gnt", 32'(gnt), 32'h1);
      a_in[7:0] = 8'h00;
      req       = '0;
      @(negedge clk);
      chk("stab_valid", 32'(rsp_valid), 32'h1);
      chk("stab_y", 32'(rsp_y), 32'h00);
      drain();

      // Reset while HOLD is waiting for ready
      req       = 4'b0100;
      rsp_ready = 1'b0;
      set_ops(2, 8'h0F, 8'h0F);
      @(negedge clk);
      chk("mid_gnt", 32'(gnt), 32'h4);
      req = '0;
      @(negedge clk);
      chk("mid_valid_pre", 32'(rsp_valid), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_valid", 32'(rsp_valid), 32'h0);
      chk("mid_gnt_off", 32'(gnt), 32'h0);
      chk("mid_y", 32'(rsp_y), 32'h0);
      chk("mid_id", 32'(rsp_id), 32'h0);
`ifdef NAND_ARB_STATS_EN
      chk("mid_cnt", grant_cnt[31:0], 32'h0);
      chk("mid_cnt_hi", grant_cnt[63:32], 32'h0);
`endif
      rst       = 1'b0;
      req       = 4'hF;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("mid_restart_gnt", 32'(gnt), 32'h1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
